// File: rtl/multiplier_if.sv
// Request/response bundle for the iterative fixed-point multiplier:
// start pulse in, busy while working, single-cycle valid with the result.
interface multiplier_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             ovf;
    logic             valid;
    logic [WIDTH-1:0] p_out;

    modport master (
        output start, a_in, b_in,
        input  busy, ovf, valid, p_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, ovf, valid, p_out
    );
endinterface

// File: rtl/multiplier.sv
// Iterative shift-add multiplier for unsigned Q(WIDTH-FRAC).FRAC operands,
// one multiplier bit per CALC cycle, truncated result with overflow flag.
module multiplier #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 5
) (
    input  logic        clk,
    input  logic        sclr,
    multiplier_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  p_out_q, p_out_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [PW-1:0]     acc_add;
    logic              last_bit;
    logic              accept;

    // Select the output window of the exact product; any set bit above it is overflow.
    function automatic logic [WIDTH:0] fmt_product(input logic [PW-1:0] p);
        logic             o;
        logic [WIDTH-1:0] q;
        o = |p[PW-1:WIDTH+FRAC];
        q = p[WIDTH+FRAC-1:FRAC];
        return {o, q};
    endfunction

    assign acc_add  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_out_d  = p_out_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                accept  = bus.start;
            end
            CALC: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_add;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d            = DONE;
                    busy_d             = 1'b0;
                    valid_d            = 1'b1;
                    {ovf_d, p_out_d}   = fmt_product(acc_add);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Operands are captured only here, so later input changes cannot leak in.
        if (accept) begin
            state_d  = CALC;
            busy_d   = 1'b1;
            mcand_d  = {{WIDTH{1'b0}}, bus.a_in};
            mplier_d = bus.b_in;
            acc_d    = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_out_q  <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_out_q  <= p_out_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.p_out = p_out_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the iterative multiplier: directed operands with
// hand-computed products, latency/handshake checks, reset and ignore cases.
module tb_multiplier;
    localparam int WIDTH = 10;
    localparam int FRAC  = 5;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    multiplier_if #(.WIDTH(WIDTH)) bus ();

    multiplier #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk (clk),
        .sclr(sclr),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] p;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   b2b_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] p, input logic o);
        exp_t e;
        e.p = p;
        e.o = o;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("p_out", 32'(bus.p_out), 32'(mon_e.p));
                check("ovf", 32'(bus.ovf), 32'(mon_e.o));
            end
        end
    end

    // glitch > 0: pulse start with other operands in that CALC cycle (must be ignored).
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ep, input logic eo, input int glitch);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        push_exp(ep, eo);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == glitch) bus.start = 1'b1;
            else if (n == glitch + 1) bus.start = 1'b0;
            if (bus.busy === 1'b1) bcnt++;
            if (bus.valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        check("latency", 32'(lat), 32'd11);
        check("busy_cycles", 32'(bcnt), 32'd10);
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.valid), 32'd0);
    endtask

    task automatic expect_quiet(input int cycles, input logic [WIDTH-1:0] ep, input logic eo);
        int vcnt;
        vcnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) vcnt++;
        end
        check("quiet_valids", 32'(vcnt), 32'd0);
        check("hold_p_out", 32'(bus.p_out), 32'(ep));
        check("hold_ovf", 32'(bus.ovf), 32'(eo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sclr      = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        // start coincident with sclr must be dropped
        bus.start = 1'b1;
        bus.a_in  = 10'd80;
        bus.b_in  = 10'd32;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        sclr      = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_p_out", 32'(bus.p_out), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        expect_quiet(15, 10'd0, 1'b0);

        // 2.5 * 1.0 = 2.5
        run_op(10'd80, 10'd32, 10'd80, 1'b0, 0);
        expect_quiet(3, 10'd80, 1'b0);
        // 0.5 * 0.25 = 0.125, then smallest * smallest truncates to 0
        run_op(10'd16, 10'd8, 10'd4, 1'b0, 0);
        run_op(10'd1, 10'd1, 10'd0, 1'b0, 0);
        // 1023 * 64 = 65472 -> window 1022, high bit set
        run_op(10'd1023, 10'd64, 10'd1022, 1'b1, 0);
        expect_quiet(3, 10'd1022, 1'b1);

        // sclr in CALC cycle 5 aborts and clears the held result
        bus.start = 1'b1;
        bus.a_in  = 10'd80;
        bus.b_in  = 10'd32;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        check("abort_p_out", 32'(bus.p_out), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        expect_quiet(15, 10'd0, 1'b0);
        run_op(10'd80, 10'd32, 10'd80, 1'b0, 0);

        // zero operand with an ignored start in mid-CALC
        run_op(10'd0, 10'd1023, 10'd0, 1'b0, 4);
        expect_quiet(15, 10'd0, 1'b0);

        // back-to-back with start held high through DONE
        push_exp(10'd4, 1'b0);
        bus.start = 1'b1;
        bus.a_in  = 10'd16;
        bus.b_in  = 10'd8;
        b2b_lat   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                b2b_lat = n;
                break;
            end
        end
        check("b2b_first_latency", 32'(b2b_lat), 32'd11);
        push_exp(10'd80, 1'b0);
        bus.a_in = 10'd80;
        bus.b_in = 10'd32;
        @(negedge clk);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        b2b_lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                b2b_lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        check("b2b_spacing", 32'(b2b_lat), 32'd11);
        expect_quiet(15, 10'd80, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
